// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//
// Accepts one operation at a time and produces a registered result plus
// status flags. Add, sub, pass, undefined ops and divide-by-zero complete on
// the acceptance edge; multiply (shift-add) and divide (restoring) iterate one
// bit per clock for WIDTH clocks. The result is held in DONE until the
// consumer takes it.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   in_valid       operation presented      in_ready   accepting (IDLE only)
//   a_in, b_in     operands (WIDTH bits)    alu_operation  3-bit opcode
//   out_valid      result valid (DONE)      out_ready  consumer takes result
//   result         primary result           remainder  division remainder
//   zero, negative, carry, overflow, div_zero   status flags
//   busy           high while iterating (MUL or DIV)
// -----------------------------------------------------------------------------
module multicycle_alu #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       alu_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero,
  output logic             busy
);

  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Sequential state
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;       // multiplicand
  logic [WIDTH-1:0]   opb_q, opb_d;       // divisor
  logic [WIDTH-1:0]   acc_q, acc_d;       // product high half / partial remainder
  logic [WIDTH-1:0]   sh_q, sh_d;         // multiplier->product low / dividend->quotient
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               zero_q, zero_d;
  logic               negative_q, negative_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               div_zero_q, div_zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  // Datapath step values
  logic [WIDTH:0]     add_sum_s;
  logic [WIDTH-1:0]   sub_diff_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH-1:0]   mul_acc_s;
  logic [WIDTH-1:0]   mul_sh_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_acc_s;
  logic [WIDTH-1:0]   div_sh_s;

  // Values captured into the output registers on entry to DONE
  logic               load_s;
  logic [WIDTH-1:0]   res_s;
  logic [WIDTH-1:0]   rem_s;
  logic               carry_s;
  logic               ovf_s;
  logic               dz_s;

  // Single-step arithmetic for the immediate ops and one iteration of mul/div
  always_comb begin
    add_sum_s  = {1'b0, a_in} + {1'b0, b_in};
    sub_diff_s = a_in - b_in;

    // Shift-add: add multiplicand to the high half when the current
    // multiplier bit is set, then shift the 2*WIDTH pair right by one.
    mul_sum_s = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    mul_acc_s = mul_sum_s[WIDTH:1];
    mul_sh_s  = {mul_sum_s[0], sh_q[WIDTH-1:1]};

    // Restoring division: bring in the next dividend bit, try subtracting
    // the divisor, keep the difference only if it did not go negative.
    div_shift_s = {acc_q, sh_q[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opb_q};
    div_ge_s    = ~div_trial_s[WIDTH];
    if (div_ge_s) begin
      div_acc_s = div_trial_s[WIDTH-1:0];
    end else begin
      div_acc_s = div_shift_s[WIDTH-1:0];
    end
    div_sh_s = {sh_q[WIDTH-2:0], div_ge_s};
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    load_s      = 1'b0;
    res_s       = {WIDTH{1'b0}};
    rem_s       = {WIDTH{1'b0}};
    carry_s     = 1'b0;
    ovf_s       = 1'b0;
    dz_s        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d = a_in;
          opb_d = b_in;
          acc_d = {WIDTH{1'b0}};
          sh_d  = {WIDTH{1'b0}};
          cnt_d = {CNT_W{1'b0}};
          case (alu_operation)
            OP_ADD: begin
              load_s  = 1'b1;
              res_s   = add_sum_s[WIDTH-1:0];
              carry_s = add_sum_s[WIDTH];
              ovf_s   = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                        (add_sum_s[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
              load_s  = 1'b1;
              res_s   = sub_diff_s;
              carry_s = (a_in >= b_in);
              ovf_s   = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                        (sub_diff_s[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_MUL: begin
              state_d = S_MUL;
              sh_d    = b_in;
            end
            OP_DIV: begin
              if (b_in == {WIDTH{1'b0}}) begin
                load_s = 1'b1;
                res_s  = {WIDTH{1'b1}};
                rem_s  = a_in;
                dz_s   = 1'b1;
              end else begin
                state_d = S_DIV;
                sh_d    = a_in;
              end
            end
            OP_PASS: begin
              load_s = 1'b1;
              res_s  = a_in;
            end
            default: begin
              load_s = 1'b1;
              res_s  = {WIDTH{1'b0}};
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        acc_d = mul_acc_s;
        sh_d  = mul_sh_s;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          load_s  = 1'b1;
          res_s   = mul_sh_s;
          carry_s = (mul_acc_s != {WIDTH{1'b0}});
        end else begin
          load_s = 1'b0;
        end
      end

      S_DIV: begin
        acc_d = div_acc_s;
        sh_d  = div_sh_s;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          load_s = 1'b1;
          res_s  = div_sh_s;
          rem_s  = div_acc_s;
        end else begin
          load_s = 1'b0;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs only move when an operation completes, so partial mul/div
    // values never reach the flags.
    if (load_s) begin
      state_d     = S_DONE;
      result_d    = res_s;
      remainder_d = rem_s;
      zero_d      = (res_s == {WIDTH{1'b0}});
      negative_d  = res_s[WIDTH-1];
      carry_d     = carry_s;
      overflow_d  = ovf_s;
      div_zero_d  = dz_s;
    end else begin
      result_d = result_q;
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_MUL) || (state_d == S_DIV);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opa_q       <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      sh_q        <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
//
// Directed bench for multicycle_alu at WIDTH=8. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_alu;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   alu_operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;
  logic         div_zero;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_alu #(.WIDTH(W), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a_in          (a_in),
    .b_in          (b_in),
    .alu_operation (alu_operation),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .remainder     (remainder),
    .zero          (zero),
    .negative      (negative),
    .carry         (carry),
    .overflow      (overflow),
    .div_zero      (div_zero),
    .busy          (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] er, input logic [7:0] erem,
                          input logic ez, input logic en, input logic ec,
                          input logic eo, input logic edz);
    chk({tag, ".result"},    result,    er);
    chk({tag, ".remainder"}, remainder, erem);
    chk({tag, ".zero"},      zero,      ez);
    chk({tag, ".negative"},  negative,  en);
    chk({tag, ".carry"},     carry,     ec);
    chk({tag, ".overflow"},  overflow,  eo);
    chk({tag, ".div_zero"},  div_zero,  edz);
  endtask

  // Present one op, scramble inputs after acceptance, wait for the result,
  // check latency and outputs, then hand the result off.
  task automatic op_check(input string tag, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                          input logic [7:0] er, input logic [7:0] erem,
                          input logic ez, input logic en, input logic ec,
                          input logic eo, input logic edz);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    in_valid      = 1'b1;
    a_in          = a;
    b_in          = b;
    alu_operation = op;
    @(negedge clk);
    in_valid      = 1'b0;
    a_in          = 8'($urandom);
    b_in          = 8'($urandom);
    alu_operation = 3'($urandom);
    lat = 1;
    chk({tag, ".busy"}, busy, (exp_lat > 1) ? 1'b1 : 1'b0);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk_outs(tag, er, erem, ez, en, ec, eo, edz);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_after"}, out_valid, 1'b0);
    chk({tag, ".in_ready_after"},  in_ready,  1'b1);
  endtask

  initial begin
    int lat;
    int seen;
    reset         = 1'b1;
    in_valid      = 1'b0;
    a_in          = 8'h00;
    b_in          = 8'h00;
    alu_operation = 3'b000;
    out_ready     = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.in_ready",  in_ready,  1'b1);
    chk("rst.busy",      busy,      1'b0);
    chk_outs("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //            tag      op      a      b     lat result rem   z     n     c     o     dz
    op_check("add_ff_1",  3'b010, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op_check("add_7f_1",  3'b010, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    op_check("sub_80_1",  3'b001, 8'h80, 8'h01, 1, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    op_check("sub_3_5",   3'b001, 8'h03, 8'h05, 1, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    op_check("mul_15_17", 3'b100, 8'd15, 8'd17, 9, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    op_check("mul_16_16", 3'b100, 8'd16, 8'd16, 9, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op_check("div_200_7", 3'b011, 8'd200, 8'd7, 9, 8'd28, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op_check("div_5_0",   3'b011, 8'd5,  8'd0,  1, 8'hFF, 8'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    op_check("div_9_10",  3'b011, 8'd9,  8'd10, 9, 8'd0,  8'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op_check("pass_a5",   3'b101, 8'hA5, 8'h3C, 1, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    op_check("undef_000", 3'b000, 8'h12, 8'h34, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op_check("undef_111", 3'b111, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // DONE held with out_ready low while the inputs keep changing
    @(negedge clk);
    in_valid      = 1'b1;
    a_in          = 8'h10;
    b_in          = 8'h20;
    alu_operation = 3'b010;
    @(negedge clk);
    chk("hold.out_valid_start", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid      = 1'b1;
      a_in          = 8'($urandom);
      b_in          = 8'($urandom);
      alu_operation = 3'b100;
      @(negedge clk);
      chk("hold.out_valid", out_valid, 1'b1);
      chk("hold.in_ready",  in_ready,  1'b0);
      chk("hold.busy",      busy,      1'b0);
      chk_outs("hold", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold.release_in_ready", in_ready, 1'b1);
    chk("hold.release_busy",     busy,     1'b0);

    // Reset on the 4th MUL edge aborts the multiply
    in_valid      = 1'b1;
    a_in          = 8'd15;
    b_in          = 8'd17;
    alu_operation = 3'b100;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort.busy", busy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.in_ready",  in_ready,  1'b1);
    chk("abort.out_valid", out_valid, 1'b0);
    chk("abort.busy_off",  busy,      1'b0);
    chk_outs("abort", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort.no_out_valid", 64'(seen), 64'd0);
    op_check("after_abort_add", 3'b010, 8'd3, 8'd4, 1, 8'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    lat = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule
